// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA timing generator: pixel-enable divider, x/y counters and a
// registered output stage that keeps renderer colour aligned with the sync pulses.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    output logic [9:0]  hsync,
    output logic [9:0]  vsync,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        video_on,
    output logic        hs_n,
    output logic        vs_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             div_wrap;
    logic             in_hsync;
    logic             in_vsync;

    assign div_wrap    = (div == DIV_LAST);
    assign video_on    = (hsync < H_VIS) && (vsync < V_VIS);
    assign frame_start = pix_tick && (hsync == 10'd0) && (vsync == 10'd0);
    assign in_hsync    = (hsync >= HS_FIRST) && (hsync <= HS_LAST);
    assign in_vsync    = (vsync >= VS_FIRST) && (vsync <= VS_LAST);
    assign vga_sync_n  = 1'b0;

    // vga_clk is low while the output stage updates and rises mid-pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            pix_tick <= 1'b0;
            vga_clk  <= 1'b0;
        end else begin
            div      <= div_wrap ? '0 : div + 1'b1;
            pix_tick <= div_wrap;
            vga_clk  <= (div >= DIV_HALF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 10'd0;
            vsync <= 10'd0;
        end else if (pix_tick) begin
            if (hsync == H_LAST) begin
                hsync <= 10'd0;
                vsync <= (vsync == V_LAST) ? 10'd0 : vsync + 10'd1;
            end else begin
                hsync <= hsync + 10'd1;
            end
        end
    end

    // Samples the coordinate being left, so colour, blank and sync share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_n        <= 1'b1;
            vs_n        <= 1'b1;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_blank_n <= 1'b0;
        end else if (pix_tick) begin
            hs_n        <= !in_hsync;
            vs_n        <= !in_vsync;
            vga_blank_n <= video_on;
            vga_r       <= video_on ? rgb[23:16] : 8'd0;
            vga_g       <= video_on ? rgb[15:8]  : 8'd0;
            vga_b       <= video_on ? rgb[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunk
// instance for frame-level behaviour, both checked against a tick-count model.
module tb_vga_timing_gen;

    // shrunk timing for frame-level coverage
    localparam int SD  = 3;
    localparam int SHV = 6, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          mode = 0;
    logic [23:0] key = 24'd0;
    int          e = 0;
    int          vectors = 0;
    int          errors = 0;

    logic [23:0] rgb_a, rgb_s;
    logic [9:0]  h_a, v_a, h_s, v_s;
    logic        tick_a, fs_a, von_a, hs_a, vs_a, bl_a, sn_a, vc_a;
    logic        tick_s, fs_s, von_s, hs_s, vs_s, bl_s, sn_s, vc_s;
    logic [7:0]  r_a, g_a, b_a, r_s, g_s, b_s;

    always #5 clk = ~clk;

    function automatic logic [23:0] rgb_fn(input int m, input logic [23:0] k,
                                           input logic [9:0] x, input logic [9:0] y);
        if (m == 0) return 24'hFFFF00;
        if (m == 1) return {x[7:0], y[7:0], 8'h5A};
        return {x[7:0] ^ k[7:0], y[7:0] ^ k[15:8], k[23:16] ^ x[7:0]};
    endfunction

    assign rgb_a = rgb_fn(mode, key, h_a, v_a);
    assign rgb_s = rgb_fn(mode, key, h_s, v_s);

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .rgb(rgb_a), .hsync(h_a), .vsync(v_a),
        .pix_tick(tick_a), .frame_start(fs_a), .video_on(von_a),
        .hs_n(hs_a), .vs_n(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_blank_n(bl_a), .vga_sync_n(sn_a), .vga_clk(vc_a)
    );

    vga_timing_gen #(
        .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .clk(clk), .rst(rst), .rgb(rgb_s), .hsync(h_s), .vsync(v_s),
        .pix_tick(tick_s), .frame_start(fs_s), .video_on(von_s),
        .hs_n(hs_s), .vs_n(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .vga_blank_n(bl_s), .vga_sync_n(sn_s), .vga_clk(vc_s)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // e = clock edges since reset release; the model derives everything from it.
    task automatic check_inst(input string p, input int d,
                              input int hv, input int hf, input int hs, input int hb,
                              input int vv, input int vf, input int vs, input int vb,
                              input logic [9:0] o_h, input logic [9:0] o_v,
                              input logic o_tick, input logic o_fs, input logic o_von,
                              input logic o_hs, input logic o_vs,
                              input logic [7:0] o_r, input logic [7:0] o_g, input logic [7:0] o_b,
                              input logic o_bl, input logic o_sn, input logic o_vc);
        int ht, vt, n, x, y, m, sx, sy;
        logic tick, vc, vis, s_vis, exp_hs, exp_vs;
        logic [23:0] col;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        n    = (e == 0) ? 0 : (e - 1) / d;
        x    = n % ht;
        y    = (n / ht) % vt;
        tick = (e > 0) && (e % d == 0);
        vc   = (e > 0) && (((e - 1) % d) >= d / 2);
        vis  = (x < hv) && (y < vv);
        if (n == 0) begin
            exp_hs = 1'b1; exp_vs = 1'b1; s_vis = 1'b0; col = 24'd0;
        end else begin
            m      = n - 1;
            sx     = m % ht;
            sy     = (m / ht) % vt;
            exp_hs = !((sx >= hv + hf) && (sx < hv + hf + hs));
            exp_vs = !((sy >= vv + vf) && (sy < vv + vf + vs));
            s_vis  = (sx < hv) && (sy < vv);
            col    = s_vis ? rgb_fn(mode, key, 10'(sx), 10'(sy)) : 24'd0;
        end
        cmp({p, ".hsync"}, 32'(o_h), 32'(x));
        cmp({p, ".vsync"}, 32'(o_v), 32'(y));
        cmp({p, ".pix_tick"}, 32'(o_tick), 32'(tick));
        cmp({p, ".frame_start"}, 32'(o_fs), 32'(tick && x == 0 && y == 0));
        cmp({p, ".video_on"}, 32'(o_von), 32'(vis));
        cmp({p, ".hs_n"}, 32'(o_hs), 32'(exp_hs));
        cmp({p, ".vs_n"}, 32'(o_vs), 32'(exp_vs));
        cmp({p, ".rgb_out"}, {8'd0, o_r, o_g, o_b}, {8'd0, col});
        cmp({p, ".blank_n"}, 32'(o_bl), 32'(s_vis));
        cmp({p, ".sync_n"}, 32'(o_sn), 32'd0);
        cmp({p, ".vga_clk"}, 32'(o_vc), 32'(vc));
    endtask

    task automatic check_all();
        check_inst("full", 2, 640, 16, 96, 48, 480, 10, 2, 33,
                   h_a, v_a, tick_a, fs_a, von_a, hs_a, vs_a, r_a, g_a, b_a, bl_a, sn_a, vc_a);
        check_inst("small", SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
                   h_s, v_s, tick_s, fs_s, von_s, hs_s, vs_s, r_s, g_s, b_s, bl_s, sn_s, vc_s);
    endtask

    task automatic run(input int ncyc);
        repeat (ncyc) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Asserted away from any clock edge so the clear must be asynchronous.
    task automatic do_reset(input int m);
        @(negedge clk);
        rst  = 1'b1;
        e    = 0;
        mode = m;
        key  = 24'($urandom);
        #1;
        check_all();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        do_reset(0);
        run(1700);
        do_reset(1);
        run(1000);
        do_reset(2);
        run($urandom_range(300, 700));
        do_reset(2);
        run($urandom_range(400, 900));
        do_reset(1);
        run(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
